enemy_ai_ctrl: RTL and testbench
================================

// Module: enemy_ai_ctrl
// PURPOSE
//  Per-enemy movement brain feeding the enemy motion block's dir input. One instance per enemy slot.
//  Picks a direction once per frame from the enemy type, own position and player position:
//  bats wander randomly, ReDeads sleep then chase, sliders patrol vertically.
//  Dir codes: 0 stop, 1 left (-X), 2 right (+X), 3 down (+Y), 4 up (-Y).
// PARAMETERS
//  HOLD_FRAMES   16       frames a wander direction is held before a new random pick
//  CHASE_FRAMES  8        frames between chase re-evaluations
//  WAKE_DIST     11'd160  Manhattan distance (px) at or below which a sleeping ReDead wakes
//  STALL_FRAMES  4        blocked-check window, in frames
//  SEED          16'hACE1 LFSR base seed
// PORTS
//  Clk          in   1   system clock
//  Reset        in   1   reset; synchronous, active-high
//  frame_clk    in   1   vsync-rate frame clock, sampled on Clk
//  initialize   in   1   room (re)load strobe, level, any length
//  active       in   1   enemy alive, from the motion block
//  enemy_type   in   2   0 none, 1 Keese, 2 ReDead, 3 Slider
//  enemy_num    in   3   slot number 1..5; decorrelates LFSR seed
//  Enemy_X/Y    in   10  enemy top-left position (unsigned px)
//  Player_X/Y   in   10  player top-left position (unsigned px)
//  dir          out  3   movement command to the motion block
//  ai_state     out  3   current FSM state encoding (debug)
// BEHAVIOUR
//  - Reset: dir=0, state=IDLE, counters=0, LFSR=SEED^{enemy_num,13'b0}^16'h0001 (never zero).
//  - tick = frame_clk rising edge: frame_clk_d registered on Clk, tick = frame_clk & ~frame_clk_d.
//    All state/dir updates happen only on tick cycles; the LFSR advances every Clk.
//  - LFSR: 16-bit Galois, taps 16'hB400. Random dir = lfsr[1:0]+1 (always 1..4).
//  - States: IDLE=0, WANDER=1, SLEEP=2, CHASE=3, PATROL=4.
//  - initialize=1 on any cycle (tick or not): state<=IDLE, dir<=0, counters<=0, LFSR reseeded.
//    This has priority over tick.
//  - IDLE: dir=0. On tick with active & ~initialize: type1->WANDER (random dir, hold_cnt=0);
//    type2->SLEEP; type3->PATROL, dir=3. type0 stays IDLE.
//  - Any state, tick with active=0: ->IDLE, dir=0. A killed enemy stops within 1 frame.
//  - WANDER: hold_cnt++ per tick. When hold_cnt==HOLD_FRAMES-1, or on blocked:
//    new random dir, hold_cnt=0. The new dir may equal the old one.
//  - SLEEP: dir=0. Each tick: dist = |Px-Ex|+|Py-Ey| (11-bit, no overflow).
//    If dist<=WAKE_DIST -> CHASE; the direction is evaluated on that same tick. No return to SLEEP until initialize.
//  - CHASE: evaluate on the entry tick, then every CHASE_FRAMES ticks.
//    adx=|Px-Ex|, ady=|Py-Ey|. adx==0 & ady==0 -> 0.
//    Else adx>=ady -> (Px<Ex ? 1 : 2); otherwise -> (Py<Ey ? 4 : 3). Ties favour X.
//  - PATROL: dir stays 3 or 4. Blocked, or Ey<=16 while dir=4, or Ey>=432 while dir=3 -> flip 3<->4.
//  - Blocked detect (WANDER/PATROL only): snapshot Enemy_X/Y every STALL_FRAMES ticks.
//    Blocked if both |X-snapX|<=1 and |Y-snapY|<=1 at the next snapshot while dir!=0.
//    Snapshot and window counter are cleared on state entry, so the first window never flags.
//  - Subtractions use compare-then-subtract; no signed wrap. Positions of 700 (offscreen) are legal inputs.
//  - dir is registered: it changes the Clk cycle after the deciding tick and holds between ticks.
// CONFIGURATION
//  - ENEMY_AI_PAUSE_EN defined: adds input `pause` (1 bit).
//    While pause=1: dir forced to 0 combinationally. FSM, counters and snapshots are frozen
//    (ticks ignored); the LFSR still runs. On release, the previous dir and state resume.
//  - Undefined: no pause port; behaviour is as above.
// TESTING
//  1. Reset held 3 clks, then type=1, active=1, 1 tick -> dir in 1..4, ai_state=1.
//     Dir is constant for 16 ticks and re-picked on the 16th.
//  2. Type=2, E=(300,200), P=(20,20): dist 460 -> dir=0, SLEEP.
//     Move P to (250,150): dist 100 -> CHASE; adx=ady=50 -> dir=1 on that tick.
//  3. CHASE, E=(100,100), P=(100,300) -> dir=3. P moved to (100,100) -> dir=0 at next 8-tick evaluation.
//  4. Type=3, Ey stepped 2px/tick from 400 -> dir flips 3->4 on the tick Ey>=432.
//     Ey frozen at 200 -> flips after one full stall window (<=8 ticks).
//  5. active drops mid-WANDER -> dir=0 on next tick.
//     initialize pulse between ticks -> dir=0 and IDLE the cycle after, without waiting for a tick.
//  6. ENEMY_AI_PAUSE_EN: pause=1 for 20 ticks in WANDER -> dir=0 and hold_cnt unchanged.
//     Release -> prior dir restored immediately.

Source files
------------

// File: rtl/enemy_ai_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// enemy_ai_if
// Bundles the per-enemy AI inputs (frame clock, room load strobe, enemy and
// player state) and the AI outputs (dir, ai_state) into one connection.
//
// Signal summary:
//   frame_clk   1   vsync-rate frame clock, sampled on the system clock
//   initialize  1   room (re)load strobe, level, any length
//   active      1   enemy alive
//   enemy_type  2   0 none, 1 Keese, 2 ReDead, 3 Slider
//   enemy_num   3   slot number 1..5, decorrelates the LFSR seed
//   Enemy_X/Y   10  enemy top-left position (px)
//   Player_X/Y  10  player top-left position (px)
//   pause       1   only when ENEMY_AI_PAUSE_EN is defined
//   dir         3   movement command (0 stop, 1 left, 2 right, 3 down, 4 up)
//   ai_state    3   FSM state encoding (debug)
//
// Handshake: there is no valid/ready pair. Inputs are level signals sampled on
// every Clk edge; a decision is taken only on a frame tick (rising edge of
// frame_clk seen on Clk), and dir/ai_state are valid from the Clk cycle after
// that tick until the next decision.
//
// Modports: master drives the inputs and observes dir/ai_state; slave is the
// AI controller.
// -----------------------------------------------------------------------------
interface enemy_ai_if;
  logic       frame_clk;
  logic       initialize;
  logic       active;
  logic [1:0] enemy_type;
  logic [2:0] enemy_num;
  logic [9:0] Enemy_X;
  logic [9:0] Enemy_Y;
  logic [9:0] Player_X;
  logic [9:0] Player_Y;
  logic [2:0] dir;
  logic [2:0] ai_state;
`ifdef ENEMY_AI_PAUSE_EN
  logic       pause;

  modport master (
    output frame_clk, initialize, active, enemy_type, enemy_num,
    output Enemy_X, Enemy_Y, Player_X, Player_Y, pause,
    input  dir, ai_state
  );

  modport slave (
    input  frame_clk, initialize, active, enemy_type, enemy_num,
    input  Enemy_X, Enemy_Y, Player_X, Player_Y, pause,
    output dir, ai_state
  );
`else
  modport master (
    output frame_clk, initialize, active, enemy_type, enemy_num,
    output Enemy_X, Enemy_Y, Player_X, Player_Y,
    input  dir, ai_state
  );

  modport slave (
    input  frame_clk, initialize, active, enemy_type, enemy_num,
    input  Enemy_X, Enemy_Y, Player_X, Player_Y,
    output dir, ai_state
  );
`endif
endinterface

// File: rtl/enemy_ai_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// enemy_ai_ctrl
// Per-enemy movement brain. Once per frame it picks a direction for the
// enemy motion block: Keese wander randomly, ReDeads sleep until the player
// is close and then chase, Sliders patrol up and down.
//
// Ports:
//   Clk    in  system clock
//   Reset  in  synchronous, active-high reset
//   bus    enemy_ai_if.slave (frame_clk, initialize, active, enemy_type,
//          enemy_num, Enemy_X/Y, Player_X/Y, dir, ai_state [, pause])
//
// Optional feature: define ENEMY_AI_PAUSE_EN to add bus.pause. While paused
// dir reads 0, frame ticks are ignored (state, counters, snapshots frozen),
// and the LFSR keeps running; on release the held dir reappears at once.
// -----------------------------------------------------------------------------
module enemy_ai_ctrl #(
  parameter int          HOLD_FRAMES  = 16,
  parameter int          CHASE_FRAMES = 8,
  parameter logic [10:0] WAKE_DIST    = 11'd160,
  parameter int          STALL_FRAMES = 4,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  enemy_ai_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WANDER = 3'd1,
    S_SLEEP  = 3'd2,
    S_CHASE  = 3'd3,
    S_PATROL = 3'd4
  } state_t;

  localparam logic [2:0] DIR_STOP  = 3'd0;
  localparam logic [2:0] DIR_LEFT  = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_UP    = 3'd4;

  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
  localparam logic [7:0] CHASE_LAST = 8'(CHASE_FRAMES - 1);
  localparam logic [7:0] STALL_LAST = 8'(STALL_FRAMES - 1);

  // Compare first so unsigned positions never wrap.
  function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_dir, w_dir_nxt;
  logic [7:0]  r_hold_cnt, w_hold_nxt;
  logic [7:0]  r_chase_cnt, w_chase_nxt;
  logic [7:0]  r_stall_cnt, w_stall_nxt;
  logic [9:0]  r_snap_x, w_snap_x_nxt;
  logic [9:0]  r_snap_y, w_snap_y_nxt;
  logic        r_snap_vld, w_snap_vld_nxt;
  logic        r_frame_clk_d;
  logic [15:0] r_lfsr;

  logic        w_tick, w_pause, w_step;
  logic [15:0] w_seed, w_lfsr_next;
  logic [2:0]  w_rand_dir, w_chase_dir;
  logic [9:0]  w_adx, w_ady, w_sdx, w_sdy;
  logic [10:0] w_dist;
  logic        w_window_end, w_blocked, w_patrol_flip;

`ifdef ENEMY_AI_PAUSE_EN
  assign w_pause = bus.pause;
  assign bus.dir = bus.pause ? DIR_STOP : r_dir;
`else
  assign w_pause = 1'b0;
  assign bus.dir = r_dir;
`endif
  assign bus.ai_state = r_state;

  assign w_tick = bus.frame_clk & ~r_frame_clk_d;
  assign w_step = w_tick & ~w_pause;

  // Slot number lands in the top bits; the low-bit XOR keeps the seed nonzero.
  assign w_seed      = SEED ^ {bus.enemy_num, 13'b0} ^ 16'h0001;
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  assign w_rand_dir  = {1'b0, r_lfsr[1:0]} + 3'd1;

  assign w_adx  = abs_diff(bus.Player_X, bus.Enemy_X);
  assign w_ady  = abs_diff(bus.Player_Y, bus.Enemy_Y);
  assign w_dist = {1'b0, w_adx} + {1'b0, w_ady};

  // Ties go to the X axis.
  always_comb begin
    w_chase_dir = DIR_STOP;
    if ((w_adx != 10'd0) || (w_ady != 10'd0)) begin
      if (w_adx >= w_ady) w_chase_dir = (bus.Player_X < bus.Enemy_X) ? DIR_LEFT : DIR_RIGHT;
      else                w_chase_dir = (bus.Player_Y < bus.Enemy_Y) ? DIR_UP : DIR_DOWN;
    end
  end

  // Stall window: the snapshot becomes valid only after the first window,
  // so a freshly entered state can never report blocked immediately.
  assign w_sdx        = abs_diff(bus.Enemy_X, r_snap_x);
  assign w_sdy        = abs_diff(bus.Enemy_Y, r_snap_y);
  assign w_window_end = (r_stall_cnt == STALL_LAST);
  assign w_blocked    = w_window_end & r_snap_vld & (w_sdx <= 10'd1) &
                        (w_sdy <= 10'd1) & (r_dir != DIR_STOP);
  assign w_patrol_flip = w_blocked |
                         ((r_dir == DIR_UP)   && (bus.Enemy_Y <= 10'd16)) |
                         ((r_dir == DIR_DOWN) && (bus.Enemy_Y >= 10'd432));

  always_comb begin
    w_state_nxt    = r_state;
    w_dir_nxt      = r_dir;
    w_hold_nxt     = r_hold_cnt;
    w_chase_nxt    = r_chase_cnt;
    w_stall_nxt    = r_stall_cnt;
    w_snap_x_nxt   = r_snap_x;
    w_snap_y_nxt   = r_snap_y;
    w_snap_vld_nxt = r_snap_vld;

    if (w_step) begin
      if (!bus.active) begin
        w_state_nxt = S_IDLE;
        w_dir_nxt   = DIR_STOP;
      end else begin
        // Shared stall-window bookkeeping for WANDER and PATROL.
        if ((r_state == S_WANDER) || (r_state == S_PATROL)) begin
          if (w_window_end) begin
            w_snap_x_nxt   = bus.Enemy_X;
            w_snap_y_nxt   = bus.Enemy_Y;
            w_snap_vld_nxt = 1'b1;
            w_stall_nxt    = 8'd0;
          end else begin
            w_stall_nxt    = r_stall_cnt + 8'd1;
          end
        end

        case (r_state)
          S_IDLE: begin
            // Every active state is entered from IDLE, so this is the entry clear.
            w_hold_nxt     = 8'd0;
            w_chase_nxt    = 8'd0;
            w_stall_nxt    = 8'd0;
            w_snap_vld_nxt = 1'b0;
            w_dir_nxt      = DIR_STOP;
            case (bus.enemy_type)
              2'd1: begin
                w_state_nxt = S_WANDER;
                w_dir_nxt   = w_rand_dir;
              end
              2'd2: w_state_nxt = S_SLEEP;
              2'd3: begin
                w_state_nxt = S_PATROL;
                w_dir_nxt   = DIR_DOWN;
              end
              default: w_state_nxt = S_IDLE;
            endcase
          end
          S_WANDER: begin
            if ((r_hold_cnt == HOLD_LAST) || w_blocked) begin
              w_dir_nxt  = w_rand_dir;
              w_hold_nxt = 8'd0;
            end else begin
              w_hold_nxt = r_hold_cnt + 8'd1;
            end
          end
          S_SLEEP: begin
            w_dir_nxt = DIR_STOP;
            if (w_dist <= WAKE_DIST) begin
              w_state_nxt = S_CHASE;
              w_dir_nxt   = w_chase_dir;
              w_chase_nxt = 8'd0;
            end
          end
          S_CHASE: begin
            if (r_chase_cnt == CHASE_LAST) begin
              w_dir_nxt   = w_chase_dir;
              w_chase_nxt = 8'd0;
            end else begin
              w_chase_nxt = r_chase_cnt + 8'd1;
            end
          end
          S_PATROL: begin
            if (w_patrol_flip) w_dir_nxt = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_dir_nxt   = DIR_STOP;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_frame_clk_d <= 1'b0;
    else       r_frame_clk_d <= bus.frame_clk;
  end

  always_ff @(posedge Clk) begin
    if (Reset || bus.initialize) r_lfsr <= w_seed;
    else                         r_lfsr <= w_lfsr_next;
  end

  always_ff @(posedge Clk) begin
    if (Reset || bus.initialize) begin
      r_state     <= S_IDLE;
      r_dir       <= DIR_STOP;
      r_hold_cnt  <= 8'd0;
      r_chase_cnt <= 8'd0;
      r_stall_cnt <= 8'd0;
      r_snap_x    <= 10'd0;
      r_snap_y    <= 10'd0;
      r_snap_vld  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_chase_cnt <= w_chase_nxt;
      r_stall_cnt <= w_stall_nxt;
      r_snap_x    <= w_snap_x_nxt;
      r_snap_y    <= w_snap_y_nxt;
      r_snap_vld  <= w_snap_vld_nxt;
    end
  end

endmodule

// File: tb/tb_enemy_ai_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_enemy_ai_ctrl
// Randomized bench for enemy_ai_ctrl. A reference model tracks each enemy's
// behaviour frame by frame and queues the expected {ai_state, dir} for every
// frame tick; a monitor pops and compares one entry per observed tick.
// Define ENEMY_AI_PAUSE_EN on both RTL and bench to exercise pause.
// -----------------------------------------------------------------------------
module tb_enemy_ai_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  enemy_ai_if bus();

  enemy_ai_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];

  logic m_pause;
`ifdef ENEMY_AI_PAUSE_EN
  assign m_pause = bus.pause;
`else
  assign m_pause = 1'b0;
`endif

  // ---------------- reference model ----------------
  int         m_state, m_dir, m_since, m_win, m_snapx, m_snapy;
  logic [15:0] m_lfsr;
  logic        m_fcd;

  function automatic logic [15:0] seed_of(input logic [2:0] n);
    return 16'hACE1 ^ {n, 13'b0} ^ 16'h0001;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = {1'b0, v[15:1]};
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int chase_dir(input int ex, input int ey, input int px, input int py);
    int adx, ady;
    adx = iabs(px - ex);
    ady = iabs(py - ey);
    if (adx == 0 && ady == 0) return 0;
    if (adx >= ady) return (px < ex) ? 1 : 2;
    return (py < ey) ? 4 : 3;
  endfunction

  // One more frame in the stall window; a snapshot every 4th frame after
  // entry, and the comparison only counts from the second snapshot onward.
  function automatic bit stall_window(input int ex, input int ey);
    bit b;
    b = 1'b0;
    m_win = m_win + 1;
    if (m_win % 4 == 0) begin
      b = (m_win >= 8) && (iabs(ex - m_snapx) <= 1) && (iabs(ey - m_snapy) <= 1) && (m_dir != 0);
      m_snapx = ex;
      m_snapy = ey;
    end
    return b;
  endfunction

  task automatic model_frame(input int rnd);
    int ex, ey, px, py;
    bit blk;
    ex = int'(bus.Enemy_X);
    ey = int'(bus.Enemy_Y);
    px = int'(bus.Player_X);
    py = int'(bus.Player_Y);
    if (!bus.active) begin
      m_state = 0;
      m_dir   = 0;
    end else begin
      case (m_state)
        0: begin
          m_since = 0;
          m_win   = 0;
          if (bus.enemy_type == 2'd1) begin m_state = 1; m_dir = rnd; end
          else if (bus.enemy_type == 2'd2) begin m_state = 2; m_dir = 0; end
          else if (bus.enemy_type == 2'd3) begin m_state = 4; m_dir = 3; end
        end
        1: begin
          blk = stall_window(ex, ey);
          m_since = m_since + 1;
          if (m_since == 16 || blk) begin
            m_dir   = rnd;
            m_since = 0;
          end
        end
        2: begin
          if (iabs(px - ex) + iabs(py - ey) <= 160) begin
            m_state = 3;
            m_dir   = chase_dir(ex, ey, px, py);
            m_since = 0;
          end
        end
        3: begin
          m_since = m_since + 1;
          if (m_since == 8) begin
            m_dir   = chase_dir(ex, ey, px, py);
            m_since = 0;
          end
        end
        default: begin
          blk = stall_window(ex, ey);
          if (blk || (m_dir == 4 && ey <= 16) || (m_dir == 3 && ey >= 432)) m_dir = 7 - m_dir;
        end
      endcase
    end
  endtask

  always @(posedge Clk) begin : ref_model
    int  rnd;
    bit  tick;
    rnd = int'(m_lfsr[1:0]) + 1;
    if (Reset) begin
      m_fcd   = 1'b0;
      m_state = 0;
      m_dir   = 0;
      m_lfsr  = seed_of(bus.enemy_num);
    end else begin
      tick  = bus.frame_clk && !m_fcd;
      m_fcd = bus.frame_clk;
      if (bus.initialize) begin
        m_state = 0;
        m_dir   = 0;
        m_lfsr  = seed_of(bus.enemy_num);
      end else begin
        if (tick) begin
          if (m_pause) begin
            exp_q.push_back({3'(m_state), 3'd0});
          end else begin
            model_frame(rnd);
            exp_q.push_back({3'(m_state), 3'(m_dir)});
          end
        end
        m_lfsr = lfsr_step(m_lfsr);
      end
    end
  end

  // ---------------- monitor ----------------
  logic mon_fcd = 1'b0;
  logic mon_tick = 1'b0;
  always @(posedge Clk) begin
    mon_tick <= bus.frame_clk & ~mon_fcd & ~Reset & ~bus.initialize;
    mon_fcd  <= Reset ? 1'b0 : bus.frame_clk;
  end

  always @(negedge Clk) begin : monitor
    logic [5:0] e;
    if (mon_tick) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL frame_out: nothing expected, got state=%0d dir=%0d", bus.ai_state, bus.dir);
      end else begin
        e = exp_q.pop_front();
        if ({bus.ai_state, bus.dir} !== e) begin
          n_errors++;
          $display("FAIL frame_out: got state=%0d dir=%0d, expected state=%0d dir=%0d at %0t",
                   bus.ai_state, bus.dir, e[5:3], e[2:0], $time);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_now(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_tick();
    @(negedge Clk);
    bus.frame_clk = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge Clk);
  endtask

  task automatic set_pos(input int ex, input int ey, input int px, input int py);
    bus.Enemy_X  = 10'(ex);
    bus.Enemy_Y  = 10'(ey);
    bus.Player_X = 10'(px);
    bus.Player_Y = 10'(py);
  endtask

  // Room reload between ticks: the outputs must clear on the next cycle.
  task automatic pulse_init();
    @(negedge Clk);
    bus.initialize = 1'b1;
    @(negedge Clk);
    check_now("init_dir", int'(bus.dir), 0);
    check_now("init_state", int'(bus.ai_state), 0);
    bus.initialize = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    int ex, ey;
    bus.frame_clk  = 1'b0;
    bus.initialize = 1'b0;
    bus.active     = 1'b0;
    bus.enemy_type = 2'd0;
    bus.enemy_num  = 3'(int'($urandom_range(1, 5)));
    set_pos(0, 0, 0, 0);
`ifdef ENEMY_AI_PAUSE_EN
    bus.pause = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    check_now("reset_dir", int'(bus.dir), 0);
    check_now("reset_state", int'(bus.ai_state), 0);
    Reset = 1'b0;
    @(negedge Clk);
    check_now("post_reset_dir", int'(bus.dir), 0);

    // Keese wander, across several re-pick points.
    bus.enemy_type = 2'd1;
    bus.active     = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_pos($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 639), $urandom_range(0, 479));
      do_tick();
    end
    // Killed mid-wander, then revived.
    bus.active = 1'b0;
    do_tick();
    bus.active = 1'b1;
    repeat (3) do_tick();
    pulse_init();

    // ReDead asleep, then woken with an X/Y tie.
    bus.enemy_type = 2'd2;
    set_pos(300, 200, 20, 20);
    repeat (3) do_tick();
    set_pos(300, 200, 250, 150);
    do_tick();
    for (int i = 0; i < 20; i++) begin
      set_pos($urandom_range(0, 700), $urandom_range(0, 700), $urandom_range(0, 700), $urandom_range(0, 700));
      do_tick();
    end
    pulse_init();

    // Chase straight down, then player on top of the enemy.
    set_pos(100, 100, 100, 200);
    do_tick();
    set_pos(100, 100, 100, 300);
    repeat (3) do_tick();
    set_pos(100, 100, 100, 100);
    repeat (10) do_tick();
    pulse_init();

    // Slider: bottom bound, then a stalled enemy.
    bus.enemy_type = 2'd3;
    for (int i = 0; i < 20; i++) begin
      set_pos(100, 400 + 2 * i, 300, 300);
      do_tick();
    end
    set_pos(100, 200, 300, 300);
    repeat (14) do_tick();
    // Top bound while moving up.
    for (int i = 0; i < 20; i++) begin
      set_pos(100, 30 - i, 300, 300);
      do_tick();
    end
    pulse_init();

    // No enemy in the slot.
    bus.enemy_type = 2'd0;
    repeat (3) do_tick();

`ifdef ENEMY_AI_PAUSE_EN
    pulse_init();
    bus.enemy_type = 2'd1;
    repeat (4) begin
      set_pos($urandom_range(0, 639), $urandom_range(0, 479), 10, 10);
      do_tick();
    end
    @(negedge Clk);
    bus.pause = 1'b1;
    #1;
    check_now("pause_dir", int'(bus.dir), 0);
    for (int i = 0; i < 20; i++) begin
      set_pos($urandom_range(0, 639), $urandom_range(0, 479), 10, 10);
      do_tick();
    end
    @(negedge Clk);
    bus.pause = 1'b0;
    #1;
    check_now("unpause_dir", int'(bus.dir), m_dir);
    check_now("unpause_state", int'(bus.ai_state), m_state);
    for (int i = 0; i < 20; i++) begin
      set_pos($urandom_range(0, 639), $urandom_range(0, 479), 10, 10);
      do_tick();
    end
`endif

    // Mixed random traffic, including stalled enemies and reloads.
    ex = 320;
    ey = 240;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        bus.enemy_num  = 3'(int'($urandom_range(1, 5)));
        bus.enemy_type = 2'(int'($urandom_range(0, 3)));
        pulse_init();
      end
      bus.active = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 2))
        0: ;
        1: begin
          ex = ex + int'($urandom_range(0, 4)) - 2;
          ey = ey + int'($urandom_range(0, 4)) - 2;
        end
        default: begin
          ex = $urandom_range(0, 700);
          ey = $urandom_range(0, 700);
        end
      endcase
      if (ex < 0) ex = 0;
      if (ey < 0) ey = 0;
      if (ex > 700) ex = 700;
      if (ey > 700) ey = 700;
      set_pos(ex, ey, $urandom_range(0, 700), $urandom_range(0, 700));
      do_tick();
    end

    repeat (4) @(negedge Clk);
    check_now("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
